nap_timer_ctrl: RTL and testbench

- Sequencer for the nap countdown and for the display time multiplexer.
- Holds a nap preset, lets the user edit it with buttons, and counts it down in BCD on a 1 Hz tick.
- Raises an alarm when the countdown expires.
- Drives the select line of the 24-bit two-way time mux, choosing between wall-clock time (time1) and nap time (time2).

---
 rtl/nap_pkg.sv | 44 ++++
 rtl/nap_bcd_dec.sv | 23 ++
 rtl/nap_timer_ctrl.sv | 137 +++++++++++++
 tb/tb_nap_timer_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nap_pkg.sv
// Shared types, BCD field positions and digit helpers for the nap timer.
package nap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_ALARM = 3'd5
  } nap_state_t;

  localparam int HH_HI = 23;
  localparam int HH_LO = 16;
  localparam int MM_HI = 15;
  localparam int MM_LO = 8;
  localparam int SS_HI = 7;
  localparam int SS_LO = 0;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Two-digit BCD +1, wrapping to 00 once the field is at max.
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    if (v[3:0] == 4'h9)
      return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD -bin; returns {borrow_out, value}, wrapping 00 to max.
  function automatic logic [8:0] bcd_dec_field(input logic [7:0] v, input logic bin,
                                               input logic [7:0] max);
    if (!bin)
      return {1'b0, v};
    if (v == 8'h00)
      return {1'b1, max};
    if (v[3:0] == 4'h0)
      return {1'b0, v[7:4] - 4'd1, 4'h9};
    return {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/nap_bcd_dec.sv
// Combinational HHMMSS minus one second with per-field borrow and a result-zero flag.
module nap_bcd_dec
  import nap_pkg::*;
(
  input  logic [23:0] time_in,
  output logic [23:0] time_out,
  output logic        zero
);

  logic [8:0] ss_r;
  logic [8:0] mm_r;
  logic [8:0] hh_r;

  always_comb begin
    ss_r     = bcd_dec_field(time_in[SS_HI:SS_LO], 1'b1,    MINSEC_MAX);
    mm_r     = bcd_dec_field(time_in[MM_HI:MM_LO], ss_r[8], MINSEC_MAX);
    hh_r     = bcd_dec_field(time_in[HH_HI:HH_LO], mm_r[8], HOUR_MAX);
    time_out = {hh_r[7:0], mm_r[7:0], ss_r[7:0]};
    // An hours borrow means the input was already zero, which is not a zero result.
    zero     = (time_out == 24'h000000) && !hh_r[8];
  end

endmodule

// File: rtl/nap_timer_ctrl.sv
// Nap preset editor, BCD countdown, alarm timeout and display-mux select.
module nap_timer_ctrl
  import nap_pkg::*;
#(
  parameter logic [23:0] DEFAULT_NAP = 24'h002000,
  parameter int unsigned ALARM_SECS  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_start,
  input  logic        btn_inc,
  output logic [23:0] nap_time,
  output logic        disp_sel,
  output logic        alarm,
  output logic        running
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS);

  nap_state_t  state;
  nap_state_t  state_nx;
  logic [23:0] preset;
  logic [23:0] preset_nx;
  logic [23:0] nap_nx;
  logic [7:0]  alarm_cnt;
  logic [7:0]  alarm_cnt_nx;
  logic [7:0]  alarm_cnt_inc;
  logic [23:0] dec_time;
  logic        dec_zero;
  logic        ev_mode;
  logic        ev_start;
  logic        ev_inc;
  logic        ev_tick;

  // Only the highest-priority event in a cycle is allowed to act.
  assign ev_mode       = btn_mode;
  assign ev_start      = btn_start & ~btn_mode;
  assign ev_inc        = btn_inc & ~btn_start & ~btn_mode;
  assign ev_tick       = tick_1hz & ~btn_inc & ~btn_start & ~btn_mode;
  assign alarm_cnt_inc = alarm_cnt + 8'd1;

  nap_bcd_dec u_dec (
    .time_in  (nap_time),
    .time_out (dec_time),
    .zero     (dec_zero)
  );

  always_comb begin
    state_nx     = state;
    preset_nx    = preset;
    nap_nx       = nap_time;
    alarm_cnt_nx = alarm_cnt;
    case (state)
      ST_IDLE: begin
        if (ev_mode) begin
          state_nx               = ST_SET_H;
          preset_nx[SS_HI:SS_LO] = 8'h00;
        end else if (ev_start && preset != 24'h000000) begin
          state_nx = ST_RUN;
        end
      end
      ST_SET_H: begin
        if (ev_mode)
          state_nx = ST_SET_M;
        else if (ev_start)
          state_nx = ST_IDLE;
        else if (ev_inc)
          preset_nx[HH_HI:HH_LO] = bcd_inc_wrap(preset[HH_HI:HH_LO], HOUR_MAX);
      end
      ST_SET_M: begin
        if (ev_mode || ev_start)
          state_nx = ST_IDLE;
        else if (ev_inc)
          preset_nx[MM_HI:MM_LO] = bcd_inc_wrap(preset[MM_HI:MM_LO], MINSEC_MAX);
      end
      ST_RUN: begin
        if (ev_mode) begin
          state_nx = ST_IDLE;
        end else if (ev_start) begin
          state_nx = ST_PAUSE;
        end else if (ev_tick) begin
          nap_nx = dec_time;
          if (dec_zero)
            state_nx = ST_ALARM;
        end
      end
      ST_PAUSE: begin
        if (ev_mode)
          state_nx = ST_IDLE;
        else if (ev_start)
          state_nx = ST_RUN;
      end
      ST_ALARM: begin
        if (ev_mode || ev_start || ev_inc) begin
          state_nx     = ST_IDLE;
          alarm_cnt_nx = 8'd0;
        end else if (ev_tick) begin
          if (alarm_cnt_inc == ALARM_LAST) begin
            state_nx     = ST_IDLE;
            alarm_cnt_nx = 8'd0;
          end else begin
            alarm_cnt_nx = alarm_cnt_inc;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Outside a countdown the nap display mirrors the preset, and a new run starts from it.
    if (state_nx == ST_IDLE || state_nx == ST_SET_H || state_nx == ST_SET_M ||
        (state == ST_IDLE && state_nx == ST_RUN))
      nap_nx = preset_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      preset    <= DEFAULT_NAP;
      nap_time  <= DEFAULT_NAP;
      alarm_cnt <= 8'd0;
      disp_sel  <= 1'b0;
      alarm     <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nx;
      preset    <= preset_nx;
      nap_time  <= nap_nx;
      alarm_cnt <= alarm_cnt_nx;
      disp_sel  <= (state_nx == ST_SET_H) || (state_nx == ST_SET_M) ||
                   (state_nx == ST_RUN)   || (state_nx == ST_PAUSE);
      alarm     <= (state_nx == ST_ALARM);
      running   <= (state_nx == ST_RUN);
    end
  end

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Directed bench for nap_timer_ctrl: vector table plus multi-cycle sequences.
module tb_nap_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] nap_time;
  logic        disp_sel;
  logic        alarm;
  logic        running;

  int total = 0;
  int bad = 0;

  nap_timer_ctrl #(
    .DEFAULT_NAP (24'h002000),
    .ALARM_SECS  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_start (btn_start),
    .btn_inc   (btn_inc),
    .nap_time  (nap_time),
    .disp_sel  (disp_sel),
    .alarm     (alarm),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        m;
    logic        s;
    logic        i;
    logic        t;
    logic [23:0] nap;
    logic        disp;
    logic        alm;
    logic        run;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input string nm, input logic m, input logic s, input logic i,
                              input logic t, input logic [23:0] nap, input logic d,
                              input logic a, input logic r);
    vec_t v;
    v.name = nm; v.m = m; v.s = s; v.i = i; v.t = t;
    v.nap = nap; v.disp = d; v.alm = a; v.run = r;
    return v;
  endfunction

  task automatic check(input string nm, input logic [23:0] en, input logic ed,
                       input logic ea, input logic er);
    total++;
    if (nap_time !== en || disp_sel !== ed || alarm !== ea || running !== er) begin
      bad++;
      $display("FAIL %s: got nap=%06h disp=%0b alarm=%0b run=%0b, want nap=%06h disp=%0b alarm=%0b run=%0b",
               nm, nap_time, disp_sel, alarm, running, en, ed, ea, er);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic m, input logic s, input logic i, input logic t);
    btn_mode = m; btn_start = s; btn_inc = i; tick_1hz = t;
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_start = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic pulses(input logic m, input logic s, input logic i, input logic t, input int n);
    for (int k = 0; k < n; k++) step(m, s, i, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pulses(1'b0, 1'b0, 1'b0, 1'b0, 2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk("start",       0, 1, 0, 0, 24'h002000, 1, 0, 1);
    vecs[1]  = mk("tick1",       0, 0, 0, 1, 24'h001959, 1, 0, 1);
    vecs[2]  = mk("tick2",       0, 0, 0, 1, 24'h001958, 1, 0, 1);
    vecs[3]  = mk("tick3",       0, 0, 0, 1, 24'h001957, 1, 0, 1);
    vecs[4]  = mk("pause_prio",  0, 1, 0, 1, 24'h001957, 1, 0, 0);
    vecs[5]  = mk("pause_hold",  0, 0, 0, 1, 24'h001957, 1, 0, 0);
    vecs[6]  = mk("resume",      0, 1, 0, 0, 24'h001957, 1, 0, 1);
    vecs[7]  = mk("tick4",       0, 0, 0, 1, 24'h001956, 1, 0, 1);
    vecs[8]  = mk("run_abort",   1, 0, 0, 0, 24'h002000, 0, 0, 0);
    vecs[9]  = mk("enter_set_h", 1, 0, 0, 0, 24'h002000, 1, 0, 0);
    vecs[10] = mk("inc_hour",    0, 0, 1, 0, 24'h012000, 1, 0, 0);
    vecs[11] = mk("enter_set_m", 1, 0, 0, 0, 24'h012000, 1, 0, 0);
    vecs[12] = mk("inc_min",     0, 0, 1, 0, 24'h012100, 1, 0, 0);
    vecs[13] = mk("start_prio",  0, 1, 1, 0, 24'h012100, 0, 0, 0);
    vecs[14] = mk("start_edit",  0, 1, 0, 0, 24'h012100, 1, 0, 1);
    vecs[15] = mk("tick_edit",   0, 0, 0, 1, 24'h012059, 1, 0, 1);
    vecs[16] = mk("mode_prio",   1, 0, 0, 1, 24'h012100, 0, 0, 0);

    do_reset();
    check("reset", 24'h002000, 0, 0, 0);
    for (int v = 0; v < 17; v++) begin
      step(vecs[v].m, vecs[v].s, vecs[v].i, vecs[v].t);
      check(vecs[v].name, vecs[v].nap, vecs[v].disp, vecs[v].alm, vecs[v].run);
    end

    // Field editing with wrap: 25 hour incs from 00, minutes zeroed then 61 incs.
    do_reset();
    step(1, 0, 0, 0);
    pulses(0, 0, 1, 0, 25);
    check("hour_wrap", 24'h012000, 1, 0, 0);
    step(1, 0, 0, 0);
    pulses(0, 0, 1, 0, 40);
    check("min_wrap", 24'h010000, 1, 0, 0);
    pulses(0, 0, 1, 0, 61);
    check("min_61", 24'h010100, 1, 0, 0);
    step(1, 0, 0, 0);
    check("set_m_to_idle", 24'h010100, 0, 0, 0);
    step(0, 1, 0, 0);
    check("run_010100", 24'h010100, 1, 0, 1);
    step(0, 0, 0, 1);
    check("borrow_min", 24'h010059, 1, 0, 1);

    // Preset 00:01:00, count to expiry, alarm timeout and button abort.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    pulses(0, 0, 1, 0, 41);
    step(1, 0, 0, 0);
    check("preset_000100", 24'h000100, 0, 0, 0);
    step(0, 1, 0, 0);
    pulses(0, 0, 0, 1, 58);
    check("count_000002", 24'h000002, 1, 0, 1);
    step(0, 0, 0, 1);
    check("count_000001", 24'h000001, 1, 0, 1);
    step(0, 0, 0, 1);
    check("expire", 24'h000000, 0, 1, 0);
    pulses(0, 0, 0, 1, 2);
    check("alarm_hold", 24'h000000, 0, 1, 0);
    step(0, 0, 0, 1);
    check("alarm_timeout", 24'h000100, 0, 0, 0);
    step(0, 1, 0, 0);
    pulses(0, 0, 0, 1, 60);
    check("expire2", 24'h000000, 0, 1, 0);
    step(0, 0, 1, 0);
    check("alarm_inc_exit", 24'h000100, 0, 0, 0);
    step(0, 1, 0, 0);
    pulses(0, 0, 0, 1, 60);
    step(1, 0, 0, 0);
    check("alarm_mode_exit", 24'h000100, 0, 0, 0);
    step(0, 0, 0, 1);
    check("idle_after_alarm", 24'h000100, 0, 0, 0);

    // Zero preset cannot start; then hour borrow and an async reset mid-run.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    pulses(0, 0, 1, 0, 59);
    check("zero_preset", 24'h000000, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("start_zero_ignored", 24'h000000, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("borrow_hour", 24'h005959, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 24'h002000, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 1, 0, 0);
    check("default_after_rst", 24'h002000, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
